// File: rtl/hh_gate_sweep_scheduler.sv
// Walks one shared Hodgkin-Huxley gate-update unit over every (neuron, gate) pair once per tick,
// clamping each result into the legal gate range before writing it back to the state store.
module hh_gate_sweep_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2,
    parameter int TIMEOUT   = 255,
    parameter int GATE_MAX  = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [15:0]      dt_in,
    output logic             busy,
    output logic             sweep_done,
    output logic             gu_req_valid,
    input  logic             gu_req_ready,
    output logic [IDX_W-1:0] gu_neuron,
    output logic [1:0]       gu_gate,
    output logic [15:0]      gu_dt,
    input  logic             gu_rsp_valid,
    input  logic [15:0]      gu_rsp_data,
    output logic             wr_en,
    output logic [IDX_W-1:0] wr_neuron,
    output logic [1:0]       wr_gate,
    output logic [15:0]      wr_data,
    output logic             overrun,
    output logic             timeout_err
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t           state;
    logic [15:0]      wait_cnt;
    logic [15:0]      rsp_clamped;
    logic             last_pair;
    logic             do_advance;
    logic [IDX_W-1:0] next_neuron;
    logic [1:0]       next_gate;

    // Responses are signed; negative values pin to zero, large ones to the full-open value.
    always_comb begin
        rsp_clamped = gu_rsp_data;
        if (gu_rsp_data[15]) begin
            rsp_clamped = '0;
        end else if (gu_rsp_data > 16'(GATE_MAX)) begin
            rsp_clamped = 16'(GATE_MAX);
        end
    end

    always_comb begin
        last_pair   = (gu_neuron == IDX_W'(N_NEURONS - 1)) && (gu_gate == 2'd2);
        next_neuron = gu_neuron;
        next_gate   = gu_gate + 2'd1;
        if (gu_gate == 2'd2) begin
            next_gate   = 2'd0;
            next_neuron = gu_neuron + IDX_W'(1);
        end
        // An abandoned request moves on exactly like a completed write, just without the strobe.
        do_advance = (state == WRITE) ||
                     ((state == WAIT) && !gu_rsp_valid && (wait_cnt == 16'(TIMEOUT - 1)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            busy         <= 1'b0;
            sweep_done   <= 1'b0;
            gu_req_valid <= 1'b0;
            gu_neuron    <= '0;
            gu_gate      <= '0;
            gu_dt        <= '0;
            wr_en        <= 1'b0;
            wr_neuron    <= '0;
            wr_gate      <= '0;
            wr_data      <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            sweep_done <= 1'b0;

            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        gu_dt        <= dt_in;
                        gu_neuron    <= '0;
                        gu_gate      <= '0;
                        gu_req_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gu_req_ready) begin
                        gu_req_valid <= 1'b0;
                        wait_cnt     <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (gu_rsp_valid) begin
                        wr_en     <= 1'b1;
                        wr_neuron <= gu_neuron;
                        wr_gate   <= gu_gate;
                        wr_data   <= rsp_clamped;
                        state     <= WRITE;
                    end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                WRITE: begin
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (do_advance) begin
                if (last_pair) begin
                    sweep_done <= 1'b1;
                    state      <= DONE;
                end else begin
                    gu_neuron    <= next_neuron;
                    gu_gate      <= next_gate;
                    gu_req_valid <= 1'b1;
                    state        <= ISSUE;
                end
            end
        end
    end

endmodule

// File: tb/tb_hh_gate_sweep_scheduler.sv
// Randomised bench for hh_gate_sweep_scheduler: a per-sweep response plan drives a behavioural
// gate unit, and expected writes, handshakes and flags are derived from that plan.
module tb_hh_gate_sweep_scheduler;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int TO    = 8;
    localparam int GMAX  = 1000;
    localparam int NP    = 3 * N;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic [15:0]      dt_in;
    logic             busy;
    logic             sweep_done;
    logic             gu_req_valid;
    logic             gu_req_ready;
    logic [IDX_W-1:0] gu_neuron;
    logic [1:0]       gu_gate;
    logic [15:0]      gu_dt;
    logic             gu_rsp_valid;
    logic [15:0]      gu_rsp_data;
    logic             wr_en;
    logic [IDX_W-1:0] wr_neuron;
    logic [1:0]       wr_gate;
    logic [15:0]      wr_data;
    logic             overrun;
    logic             timeout_err;

    hh_gate_sweep_scheduler #(
        .N_NEURONS(N), .IDX_W(IDX_W), .TIMEOUT(TO), .GATE_MAX(GMAX)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .dt_in(dt_in),
        .busy(busy), .sweep_done(sweep_done),
        .gu_req_valid(gu_req_valid), .gu_req_ready(gu_req_ready),
        .gu_neuron(gu_neuron), .gu_gate(gu_gate), .gu_dt(gu_dt),
        .gu_rsp_valid(gu_rsp_valid), .gu_rsp_data(gu_rsp_data),
        .wr_en(wr_en), .wr_neuron(wr_neuron), .wr_gate(wr_gate), .wr_data(wr_data),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-pair plan: cycles of ready held low, response delay in wait cycles, raw response value.
    int plan_stall [NP];
    int plan_delay [NP];
    int plan_data  [NP];

    int  cyc = 0, exp_done_at = -10, obs_done_cyc = -1, tick_cyc = -1, sweeps_done = 0;
    int  wait_idx = 0, pair = 0, cur_pair = 0, stall_left = 0;
    int  ew_n = 0, ew_g = 0, ew_d = 0;
    bit  active = 0, in_wait = 0, accept_pending = 0, rsp_sent = 0;
    bit  tick_pending = 0, ovr_pending = 0, exp_to = 0, exp_ovr = 0, want_tick = 0, want_ovr = 0;
    logic [15:0] m_dt = '0, want_dt = '0, ovr_dt = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int clampGate(input int v);
        if (v < 0) return 0;
        if (v > GMAX) return GMAX;
        return v;
    endfunction

    task automatic setNominal(input int data);
        for (int i = 0; i < NP; i++) begin
            plan_stall[i] = 0;
            plan_delay[i] = 0;
            plan_data[i]  = data;
        end
    endtask

    task automatic resetModel();
        active = 0; in_wait = 0; accept_pending = 0; rsp_sent = 0;
        tick_pending = 0; ovr_pending = 0; exp_to = 0; exp_ovr = 0;
        want_tick = 0; want_ovr = 0; m_dt = '0; pair = 0; exp_done_at = -10;
        tick = 1'b0; gu_rsp_valid = 1'b0; gu_req_ready = 1'b0;
    endtask

    // One clock: advance the model for the edge just passed, compare, then drive the next inputs.
    task automatic applyStimulus();
        bit exp_valid;
        @(negedge clk);
        cyc++;
        if (exp_done_at == cyc - 1) active = 0;
        if (tick_pending) begin
            tick_pending = 0; active = 1; pair = 0; stall_left = plan_stall[0];
        end
        if (ovr_pending) begin
            ovr_pending = 0; exp_ovr = 1;
        end
        if (accept_pending) begin
            accept_pending = 0; in_wait = 1; wait_idx = 0;
        end else if (rsp_sent) begin
            in_wait = 0;
            if (cur_pair == NP - 1) exp_done_at = cyc + 1;
        end else if (in_wait) begin
            wait_idx++;
            if (wait_idx == TO) begin
                in_wait = 0; exp_to = 1;
                if (cur_pair == NP - 1) exp_done_at = cyc;
            end
        end
        exp_valid = active && !in_wait && !rsp_sent && (pair < NP);

        checkOutput("wr_en", 32'(wr_en), 32'(rsp_sent));
        if (rsp_sent) begin
            checkOutput("wr_neuron", 32'(wr_neuron), ew_n);
            checkOutput("wr_gate", 32'(wr_gate), ew_g);
            checkOutput("wr_data", 32'(wr_data), ew_d);
        end
        checkOutput("sweep_done", 32'(sweep_done), 32'(cyc == exp_done_at));
        checkOutput("busy", 32'(busy), 32'(active));
        checkOutput("req_valid", 32'(gu_req_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("req_neuron", 32'(gu_neuron), pair / 3);
            checkOutput("req_gate", 32'(gu_gate), pair % 3);
            checkOutput("req_dt", 32'(gu_dt), 32'(m_dt));
        end
        checkOutput("overrun", 32'(overrun), 32'(exp_ovr));
        checkOutput("timeout_err", 32'(timeout_err), 32'(exp_to));
        if (sweep_done === 1'b1) obs_done_cyc = cyc;
        if (cyc == exp_done_at) sweeps_done++;

        tick         = 1'b0;
        gu_rsp_valid = 1'b0;
        gu_rsp_data  = 16'($urandom);
        gu_req_ready = 1'($urandom_range(0, 1));
        rsp_sent     = 0;
        if (in_wait && wait_idx == plan_delay[cur_pair]) begin
            gu_rsp_valid = 1'b1;
            gu_rsp_data  = 16'(plan_data[cur_pair]);
            ew_n = cur_pair / 3;
            ew_g = cur_pair % 3;
            ew_d = clampGate(plan_data[cur_pair]);
            rsp_sent = 1;
        end
        if (exp_valid) begin
            if (stall_left > 0) begin
                gu_req_ready = 1'b0;
                stall_left--;
                if ($urandom_range(0, 3) == 0) gu_rsp_valid = 1'b1;
            end else begin
                gu_req_ready   = 1'b1;
                accept_pending = 1;
                cur_pair       = pair;
                pair++;
                stall_left = (pair < NP) ? plan_stall[pair] : 0;
            end
        end
        if (want_tick && !active && !tick_pending) begin
            tick = 1'b1; dt_in = want_dt; m_dt = want_dt;
            tick_pending = 1; want_tick = 0; tick_cyc = cyc;
        end else if (want_ovr && active && pair < NP) begin
            tick = 1'b1; dt_in = ovr_dt; ovr_pending = 1; want_ovr = 0;
        end
    endtask

    task automatic runSweep(input logic [15:0] dt, input int ovr_at, input logic [15:0] odt);
        int start_done;
        int k;
        want_tick    = 1;
        want_dt      = dt;
        start_done   = sweeps_done;
        obs_done_cyc = -1;
        k = 0;
        while (sweeps_done == start_done && k < 1000) begin
            if (k == ovr_at) begin
                want_ovr = 1; ovr_dt = odt;
            end
            applyStimulus();
            k++;
        end
        if (k >= 1000) checkOutput("sweep_bound", 0, 1);
        want_ovr = 0;
        applyStimulus();
        checkOutput("dt_hold", 32'(gu_dt), 32'(m_dt));
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; tick = 1'b0; dt_in = '0; gu_req_ready = 1'b0;
        gu_rsp_valid = 1'b0; gu_rsp_data = '0;
        setNominal(600);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_dt", 32'(gu_dt), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        repeat (3) applyStimulus();

        // Reset mid-wait must abort the sweep with no write or done afterwards.
        setNominal(600);
        plan_delay[0] = 6;
        want_tick = 1; want_dt = 16'd55; want_ovr = 1; ovr_dt = 16'd3;
        k = 0;
        while (!(in_wait && wait_idx >= 2) && k < 30) begin
            applyStimulus();
            k++;
        end
        checkOutput("reach_wait", 32'(in_wait), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_valid", 32'(gu_req_valid), 0);
        checkOutput("rst_dt", 32'(gu_dt), 0);
        checkOutput("rst_overrun", 32'(overrun), 0);
        checkOutput("rst_fields", 32'({gu_neuron, gu_gate, wr_en, wr_neuron, wr_gate, wr_data, sweep_done, timeout_err}), 0);
        @(negedge clk);
        resetModel();
        reset = 1'b0;
        repeat (15) applyStimulus();

        // Nominal sweep with immediate handshakes: 38 cycles from tick cycle through done cycle.
        setNominal(600);
        runSweep(16'd10, -1, '0);
        checkOutput("latency", 32'(obs_done_cyc - tick_cyc + 1), 3 * 3 * N + 2);

        // Backpressure on (2,h) and clamp boundaries.
        setNominal(600);
        plan_stall[7] = 5;
        plan_data[0] = -20;
        plan_data[1] = 1350;
        plan_data[2] = 1000;
        plan_data[3] = 0;
        plan_data[4] = 1001;
        runSweep(16'd12, -1, '0);

        // No response for (1,n): request abandoned, sweep still completes.
        setNominal(500);
        plan_delay[5] = TO + 5;
        runSweep(16'd10, -1, '0);
        checkOutput("timeout_flag", 32'(timeout_err), 1);

        // Tick during a sweep is ignored apart from the sticky flag; the next idle tick is taken.
        setNominal(600);
        runSweep(16'd10, 6, 16'd7);
        checkOutput("overrun_flag", 32'(overrun), 1);
        checkOutput("dt_kept", 32'(gu_dt), 10);
        setNominal(400);
        runSweep(16'd21, -1, '0);
        checkOutput("dt_new", 32'(gu_dt), 21);

        for (int s = 0; s < 25; s++) begin
            for (int i = 0; i < NP; i++) begin
                plan_stall[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                plan_delay[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, TO - 1);
                if ($urandom_range(0, 3) == 0)
                    plan_data[i] = int'($signed(16'($urandom)));
                else
                    plan_data[i] = $urandom_range(0, 1400) - 200;
            end
            runSweep(16'($urandom), ($urandom_range(0, 2) == 0) ? $urandom_range(2, 20) : -1, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
